fsk_tx_sequencer: RTL and testbench

FSK_TX_SEQUENCER -- requirements
Module: fsk_tx_sequencer

---
 rtl/fsk_pkg.sv | 26 ++
 rtl/fsk_bit_timer.sv | 35 +++
 rtl/fsk_tx_sequencer.sv | 142 ++++++++++++++
 tb/tb_fsk_tx_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// FSK transmit sequencer shared definitions.
// FSM states, sample/phase/data widths and the round-robin pick helper.
package fsk_pkg;

    localparam int SAMPLES_PER_CYCLE = 32;
    localparam int PHASE_W           = 5;
    localparam int DATA_W            = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } fsk_state_e;

    // With both requesters pending the pointer decides;
    // with a single one pending that one wins.
    function automatic logic rr_pick(
        input logic v0,
        input logic v1,
        input logic ptr
    );
        return (v0 && v1) ? ptr : v1;
    endfunction

endpackage

// File: rtl/fsk_bit_timer.sv
// Bit timer: free-running modulator sample index and carrier-cycle counter.
// Ports: clk, reset (async low) in; mod_phase (5b), bit_end strobe out.
module fsk_bit_timer
    import fsk_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PHASE_W-1:0] mod_phase,
    output logic               bit_end
);

    localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(SAMPLES_PER_CYCLE - 1);
    localparam logic [7:0]         CNT_LAST = 8'(CYCLES_PER_BIT - 1);

    logic [7:0] cycle_cnt;
    logic       phase_last;

    assign phase_last = (mod_phase == PH_LAST);
    assign bit_end    = phase_last && (cycle_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mod_phase <= '0;
            cycle_cnt <= '0;
        end else begin
            mod_phase <= mod_phase + 1'b1;
            if (phase_last) begin
                cycle_cnt <= (cycle_cnt == CNT_LAST) ? 8'd0 : cycle_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/fsk_tx_sequencer.sv
// FSK transmit sequencer: arbitrates two byte requesters round-robin and
// serialises start/8 data (LSB first)/stop bits aligned to carrier bit ends.
// Ports: clk, reset (async low); req0/req1 valid/data/ready handshakes;
// mod_phase, mod_bit to the modulator; busy, grant_id status.
module fsk_tx_sequencer
    import fsk_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 8,
    parameter int STOP_BITS      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [DATA_W-1:0]  req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [DATA_W-1:0]  req1_data,
    output logic               req1_ready,
    output logic [PHASE_W-1:0] mod_phase,
    output logic               mod_bit,
    output logic               busy,
    output logic               grant_id
);

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    fsk_state_e        state, state_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic              stop_cnt, stop_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              mod_bit_n;
    logic              grant_n;
    logic              rr_ptr, rr_n;

    logic bit_end;
    logic last_stop;
    logic window;
    logic winner;
    logic accept;

    fsk_bit_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .mod_phase(mod_phase),
        .bit_end  (bit_end)
    );

    assign last_stop  = (stop_cnt == STOP_LAST);
    // Acceptance only at a bit boundary while idle or ending the
    // final stop bit, so frames can chain without an idle bit.
    assign window     = bit_end &&
                        ((state == IDLE) || ((state == STOP) && last_stop));
    assign winner     = rr_pick(req0_valid, req1_valid, rr_ptr);
    assign accept     = window && (req0_valid || req1_valid);
    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            mod_bit  <= 1'b1;
            grant_id <= 1'b0;
            rr_ptr   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_idx  <= bit_idx_n;
            stop_cnt <= stop_cnt_n;
            shreg    <= shreg_n;
            mod_bit  <= mod_bit_n;
            grant_id <= grant_n;
            rr_ptr   <= rr_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        shreg_n    = shreg;
        mod_bit_n  = mod_bit;
        grant_n    = grant_id;
        rr_n       = rr_ptr;

        if (accept) begin
            shreg_n = winner ? req1_data : req0_data;
            grant_n = winner;
            rr_n    = !winner;
        end

        if (bit_end) begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state_n   = START;
                        mod_bit_n = 1'b0;
                    end
                end
                START: begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    mod_bit_n = shreg[0];
                    shreg_n   = {1'b0, shreg[DATA_W-1:1]};
                end
                DATA: begin
                    if (bit_idx == 3'd7) begin
                        state_n    = STOP;
                        stop_cnt_n = 1'b0;
                        mod_bit_n  = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        mod_bit_n = shreg[0];
                        shreg_n   = {1'b0, shreg[DATA_W-1:1]};
                    end
                end
                STOP: begin
                    if (last_stop) begin
                        if (accept) begin
                            state_n   = START;
                            mod_bit_n = 1'b0;
                        end else begin
                            state_n   = IDLE;
                            mod_bit_n = 1'b1;
                        end
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n   = IDLE;
                    mod_bit_n = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Directed bench for fsk_tx_sequencer (CYCLES_PER_BIT=2, STOP_BITS=1).
// Frame table plus hand sequences for chaining, cancel, reset and fairness.
module tb_fsk_tx_sequencer;

    localparam int CPB    = 2;
    localparam int BITLEN = 32 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic [4:0] mod_phase;
    logic       mod_bit;
    logic       busy;
    logic       grant_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    fsk_tx_sequencer #(
        .CYCLES_PER_BIT(CPB),
        .STOP_BITS     (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .mod_phase (mod_phase),
        .mod_bit   (mod_bit),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference sample counter and bit-edge alignment monitor.
    logic [4:0] ph_model;
    logic       prev_bit = 1'b1;

    always @(posedge clk or negedge reset) begin
        if (!reset) ph_model <= 5'd0;
        else        ph_model <= ph_model + 5'd1;
    end

    always @(negedge clk) begin
        if (reset) begin
            check("phase_count", 32'(mod_phase), 32'(ph_model));
            if (mod_bit !== prev_bit)
                check("edge_at_phase0", 32'(mod_phase), 32'd0);
        end
        prev_bit = mod_bit;
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input logic v0, input logic [7:0] d0,
                            input logic v1, input logic [7:0] d1);
        reset = 1'b0;
        req0_valid = v0;
        req0_data = d0;
        req1_valid = v1;
        req1_data = d1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        #1;
    endtask

    task automatic wait_ready(input int limit, output int at, output logic who);
        logic found;
        found = 1'b0;
        at = -1;
        who = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            if (req0_ready || req1_ready) begin
                found = 1'b1;
                at = cyc;
                who = req1_ready;
            end else begin
                tick();
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got none expected a grant in %0d cycles",
                     limit);
        end
    endtask

    // Sample the middle of each of the 10 frame bits following acceptance.
    task automatic rx_frame(input int acc, output logic [9:0] bits);
        int target;
        bits = '0;
        for (int b = 0; b < 10; b++) begin
            target = acc + 1 + BITLEN * b + BITLEN / 2;
            while (cyc < target) tick();
            bits[b] = mod_bit;
        end
    endtask

    typedef struct {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       who;
        logic [7:0] dat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int         at, at2;
        logic       who, who2;
        logic [9:0] bits;
        logic       early, bad;
        logic       exp_who[3];

        vecs[0] = '{v0:1'b1, v1:1'b0, d0:8'hA5, d1:8'h00, who:1'b0, dat:8'hA5};
        vecs[1] = '{v0:1'b0, v1:1'b1, d0:8'h00, d1:8'h3C, who:1'b1, dat:8'h3C};
        vecs[2] = '{v0:1'b1, v1:1'b1, d0:8'h11, d1:8'h22, who:1'b0, dat:8'h11};
        vecs[3] = '{v0:1'b1, v1:1'b0, d0:8'h00, d1:8'hFF, who:1'b0, dat:8'h00};
        vecs[4] = '{v0:1'b0, v1:1'b1, d0:8'hFF, d1:8'hFF, who:1'b1, dat:8'hFF};

        // Reset state, with a request pending to show ready stays low.
        reset = 1'b0;
        req0_valid = 1'b1;
        req0_data = 8'h77;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mod_bit", 32'(mod_bit), 32'd1);
        check("rst_phase", 32'(mod_phase), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        #1;
        check("rel_phase0", 32'(mod_phase), 32'd0);
        while (cyc < 40) tick();
        check("phase_wrap", 32'(mod_phase), 32'd8);

        // Single frames from reset.
        for (int i = 0; i < 5; i++) begin
            do_reset(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
            wait_ready(200, at, who);
            check("ready_cycle", 32'(at), 32'd63);
            check("grant_who", 32'(who), 32'(vecs[i].who));
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            check("frame_busy", 32'(busy), 32'd1);
            check("frame_grant", 32'(grant_id), 32'(vecs[i].who));
            rx_frame(at, bits);
            check("frame_bits", 32'(bits), 32'({1'b1, vecs[i].dat, 1'b0}));
            while (cyc < at + 1 + 10 * BITLEN + 2) tick();
            check("post_idle", 32'(busy), 32'd0);
            check("post_mark", 32'(mod_bit), 32'd1);
            check("post_grant", 32'(grant_id), 32'(vecs[i].who));
        end

        // Both pending: req0 first, req1 chained at the stop bit end.
        do_reset(1'b1, 8'h11, 1'b1, 8'h22);
        wait_ready(200, at, who);
        check("b2b_first_at", 32'(at), 32'd63);
        check("b2b_first_who", 32'(who), 32'd0);
        tick();
        req0_valid = 1'b0;
        check("b2b_grant0", 32'(grant_id), 32'd0);
        rx_frame(at, bits);
        check("b2b_bits0", 32'(bits), 32'({1'b1, 8'h11, 1'b0}));
        wait_ready(200, at2, who2);
        check("b2b_second_at", 32'(at2), 32'(at + 10 * BITLEN));
        check("b2b_second_who", 32'(who2), 32'd1);
        check("b2b_grant_hold", 32'(grant_id), 32'd0);
        tick();
        req1_valid = 1'b0;
        check("b2b_grant1", 32'(grant_id), 32'd1);
        check("b2b_no_gap_bit", 32'(mod_bit), 32'd0);
        check("b2b_no_gap_busy", 32'(busy), 32'd1);
        rx_frame(at2, bits);
        check("b2b_bits1", 32'(bits), 32'({1'b1, 8'h22, 1'b0}));

        // Valid raised mid-bit waits for the window.
        do_reset(1'b0, 8'h00, 1'b0, 8'h00);
        while (cyc < 10) tick();
        req1_valid = 1'b1;
        req1_data = 8'h5A;
        wait_ready(200, at, who);
        check("late_ready_at", 32'(at), 32'd63);
        check("late_ready_who", 32'(who), 32'd1);
        tick();
        req1_valid = 1'b0;

        // Valid dropped before the window cancels silently.
        do_reset(1'b0, 8'h00, 1'b0, 8'h00);
        while (cyc < 10) tick();
        req1_valid = 1'b1;
        req1_data = 8'h5A;
        early = 1'b0;
        while (cyc < 40) begin
            if (req0_ready || req1_ready) early = 1'b1;
            tick();
        end
        req1_valid = 1'b0;
        bad = 1'b0;
        while (cyc < 300) begin
            if (req0_ready || req1_ready || busy || mod_bit !== 1'b1) bad = 1'b1;
            tick();
        end
        check("cancel_no_early_ready", 32'(early), 32'd0);
        check("cancel_no_frame", 32'(bad), 32'd0);

        // Reset in DATA bit 3 of 0xA5 (a space bit) aborts the frame.
        do_reset(1'b1, 8'hA5, 1'b0, 8'h00);
        wait_ready(200, at, who);
        tick();
        req0_valid = 1'b0;
        while (cyc < 340) tick();
        check("pre_abort_bit", 32'(mod_bit), 32'd0);
        check("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_mod_bit", 32'(mod_bit), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_phase", 32'(mod_phase), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        #1;
        bad = 1'b0;
        while (cyc < 300) begin
            if (busy || mod_bit !== 1'b1 || req0_ready || req1_ready) bad = 1'b1;
            tick();
        end
        check("abort_no_resume", 32'(bad), 32'd0);

        // Fairness with both always pending.
        exp_who[0] = 1'b0;
        exp_who[1] = 1'b1;
        exp_who[2] = 1'b0;
        do_reset(1'b1, 8'h01, 1'b1, 8'h02);
        for (int k = 0; k < 3; k++) begin
            wait_ready(800, at, who);
            check("rr_at", 32'(at), 32'(63 + k * 10 * BITLEN));
            check("rr_who", 32'(who), 32'(exp_who[k]));
            tick();
            check("rr_grant", 32'(grant_id), 32'(exp_who[k]));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
